// File: rtl/accelbrot_com_pkg.sv
// accelbrot_com_pkg: shared types for the accelbrot common blocks
package accelbrot_com_pkg;
    typedef enum logic {VD_RUN, VD_DRAIN} vdelay_state_t;
endpackage

// File: rtl/accelbrot_com_tapmux.sv
// accelbrot_com_tapmux: N:1 mux of {valid, data} stages, selected by a tap index
module accelbrot_com_tapmux #(
    parameter int N  = 16,
    parameter int W  = 32,
    parameter int SW = $clog2(N + 1)
) (
    input  logic [N-1:0]  v,
    input  logic [W-1:0]  d [N],
    input  logic [SW-1:0] sel,
    output logic          v_o,
    output logic [W-1:0]  d_o
);
    always_comb begin
        v_o = 1'b0;
        d_o = d[0];
        for (int i = 0; i < N; i++)
            if (sel == SW'(i)) begin
                v_o = v[i];
                d_o = d[i];
            end
    end
endmodule

// File: rtl/accelbrot_com_vdelay.sv
// accelbrot_com_vdelay: multi-channel valid-tagged delay line with runtime latency 0..MAX_DEPTH
module accelbrot_com_vdelay
    import accelbrot_com_pkg::*;
#(
    parameter int               MAX_DEPTH  = 16,
    parameter int               WIDTH      = 32,
    parameter int               NUM_CH     = 2,
    parameter logic [WIDTH-1:0] INIT       = '0,
    parameter int               DEPTH_INIT = 1,
    localparam int              DW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clken,
    input  logic                    flush,
    input  logic [DW-1:0]           depth_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [DW-1:0]           depth_cur,
    output logic [DW-1:0]           in_flight
);
    localparam int            BW   = NUM_CH * WIDTH;
    localparam logic [DW-1:0] MAXD = DW'(MAX_DEPTH);
    vdelay_state_t state_q, state_d;
    logic [DW-1:0] depth_q, depth_d, cnt_q, cnt_d, eff_sel, tap_sel;
    logic [MAX_DEPTH-1:0] v_q, v_d;
    logic [BW-1:0] d_q [MAX_DEPTH];
    logic [BW-1:0] d_d [MAX_DEPTH];
    logic [BW-1:0] tap_d;
    logic tap_v, accept, deliver;

    assign eff_sel   = depth_sel > MAXD ? MAXD : depth_sel;
    assign in_ready  = state_q == VD_RUN && eff_sel == depth_q;
    assign accept    = in_valid && in_ready && clken && !flush;
    assign tap_sel   = depth_q - DW'(1);
    assign out_valid = depth_q == '0 ? in_valid && in_ready : tap_v;
    assign out_data  = depth_q == '0 ? in_data : tap_d;
    assign deliver   = clken && out_valid && depth_q != '0;
    assign depth_cur = depth_q;
    assign in_flight = cnt_q;

    accelbrot_com_tapmux #(.N(MAX_DEPTH), .W(BW), .SW(DW)) u_tap (
        .v   (v_q),
        .d   (d_q),
        .sel (tap_sel),
        .v_o (tap_v),
        .d_o (tap_d)
    );

    // valids beyond the tap are zeroed on every shift so a later depth increase sees no stale entries
    always_comb begin
        cnt_d   = flush ? '0 : (!clken || depth_q == '0) ? cnt_q : cnt_q + DW'(accept) - DW'(deliver);
        v_d[0]  = !flush && (clken ? accept && depth_q != '0 : v_q[0]);
        d_d[0]  = clken && !flush ? in_data : d_q[0];
        for (int i = 1; i < MAX_DEPTH; i++) begin
            v_d[i] = !flush && (clken ? v_q[i-1] && DW'(i) < depth_q : v_q[i]);
            d_d[i] = clken && !flush ? d_q[i-1] : d_q[i];
        end
        state_d = state_q;
        depth_d = depth_q;
        if (clken && !flush) begin
            if (state_q == VD_RUN)
                state_d = eff_sel != depth_q ? VD_DRAIN : VD_RUN;
            else if (cnt_d == '0) begin
                state_d = VD_RUN;
                depth_d = eff_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= VD_RUN;
            depth_q <= DW'(DEPTH_INIT);
            cnt_q   <= '0;
            v_q     <= '0;
            d_q     <= '{default: {NUM_CH{INIT}}};
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            d_q     <= d_d;
        end
    end
endmodule

// File: tb/tb_accelbrot_com_vdelay.sv
// tb_accelbrot_com_vdelay: randomized directed phases checked against a queue-based latency model
module tb_accelbrot_com_vdelay;
    localparam int          MAXD  = 16;
    localparam int          DW    = 5;
    localparam int          DINIT = 1;
    localparam logic [31:0] INIT  = 32'h0BAD_CAFE;

    logic clk = 1'b0, rstn = 1'b0, clken = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] depth_sel = DW'(DINIT);
    logic [63:0] in_data = '0;
    logic in_ready, out_valid;
    logic [63:0] out_data;
    logic [DW-1:0] depth_cur, in_flight;

    accelbrot_com_vdelay #(.MAX_DEPTH(MAXD), .WIDTH(32), .NUM_CH(2), .INIT(INIT), .DEPTH_INIT(DINIT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clken     (clken),
        .flush     (flush),
        .depth_sel (depth_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .depth_cur (depth_cur),
        .in_flight (in_flight)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] d; int age;} ent_t;
    ent_t q[$];
    int mdepth = DINIT;
    bit mdrain = 1'b0, known = 1'b0;
    int checks = 0, failures = 0;

    function automatic int eff(logic [DW-1:0] s);
        return int'(s) > MAXD ? MAXD : int'(s);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // an accepted entry is at the tap once it has aged depth-1 clken edges
    task automatic tick();
        bit er, ev;
        logic [63:0] ed;
        #1;
        er = !mdrain && eff(depth_sel) == mdepth;
        ev = mdepth == 0 ? in_valid && er : (q.size() > 0 && q[0].age == mdepth - 1);
        ed = mdepth == 0 ? in_data : (q.size() > 0 ? q[0].d : '0);
        if (known) begin
            chk("in_ready", 64'(in_ready), 64'(er));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("depth_cur", 64'(depth_cur), 64'(mdepth));
            chk("in_flight", 64'(in_flight), 64'(q.size()));
            if (ev) chk("out_data", out_data, ed);
        end
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            mdepth = DINIT;
            mdrain = 1'b0;
            known  = 1'b1;
        end else if (flush) begin
            q.delete();
        end else if (clken) begin
            if (ev && mdepth > 0) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_valid && er && mdepth > 0) q.push_back('{in_data, 0});
            if (!mdrain) mdrain = eff(depth_sel) != mdepth;
            else if (q.size() == 0) begin
                mdepth = eff(depth_sel);
                mdrain = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic switch_to(int d);
        depth_sel = DW'(d);
        clken     = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 40 && (mdepth != eff(depth_sel) || mdrain); i++) tick();
    endtask

    initial begin
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", out_data, {INIT, INIT});
        chk("rst_depth_cur", 64'(depth_cur), 64'(DINIT));
        chk("rst_in_flight", 64'(in_flight), 64'(0));
        rstn = 1'b1;
        // T1: continuous stream at depth 5
        switch_to(5);
        in_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            in_data = 64'(n);
            tick();
        end
        chk("t1_in_flight", 64'(in_flight), 64'(5));
        // T2: depth 3 with clken stalls
        switch_to(3);
        for (int n = 0; n < 30; n++) begin
            clken    = (n % 3) == 0;
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            tick();
        end
        // T3: depth 4 full, then retarget to 2
        switch_to(4);
        in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        depth_sel = DW'(2);
        for (int n = 0; n < 20; n++) begin
            in_data = {$urandom, 32'(n)};
            tick();
        end
        chk("t3_depth", 64'(depth_cur), 64'(2));
        // T4: flush with clken low drops the same-cycle input
        switch_to(6);
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        flush    = 1'b1;
        clken    = 1'b0;
        in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        flush    = 1'b0;
        clken    = 1'b1;
        in_valid = 1'b0;
        chk("t4_in_flight", 64'(in_flight), 64'(0));
        for (int n = 0; n < 10; n++) tick();
        // T5: bypass, then saturating selection
        switch_to(0);
        for (int n = 0; n < 12; n++) begin
            in_valid = 1'($urandom);
            in_data  = {$urandom, $urandom};
            tick();
        end
        switch_to(20);
        chk("t5_saturate", 64'(depth_cur), 64'(16));
        in_valid = 1'b1;
        for (int n = 0; n < 24; n++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        // T6: reset with items in flight
        switch_to(7);
        in_valid = 1'b1;
        for (int n = 0; n < 7; n++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        in_valid = 1'b0;
        depth_sel = DW'(DINIT);
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_out_data", out_data, {INIT, INIT});
        chk("t6_depth_cur", 64'(depth_cur), 64'(DINIT));
        // random soak over every control
        for (int n = 0; n < 800; n++) begin
            rstn     = $urandom_range(0, 199) != 0;
            flush    = $urandom_range(0, 29) == 0;
            clken    = $urandom_range(0, 3) != 0;
            in_valid = $urandom_range(0, 3) != 0;
            in_data  = {$urandom, $urandom};
            if ($urandom_range(0, 24) == 0) depth_sel = DW'($urandom_range(0, 31));
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
